rr_arbiter_8: RTL and testbench
===============================

Name: rr_arbiter_8

Overview:
- Round-robin arbiter that shares one resource among 8 requesters.
- Outputs a registered one-hot grant plus its 3-bit index, using the team's 8-to-3 one-hot encoder.
- The grant is held until the owner signals done, drops its request, or exceeds a hold-time limit.
- Sits between request sources and a shared bus or resource; the index drives the downstream select mux.

Parameters:
- HOLD_W, 8, width of the hold-time counter.
- MAX_HOLD, 255, maximum cycles one owner may hold the grant. 0 disables the timeout. Must be < 2^HOLD_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  8  request vector; bit i = requester i.
- done  input  1  current owner releases the resource. Ignored when no grant is active.
- gnt  output  8  one-hot grant, registered; all zero when idle.
- gnt_idx  output  3  binary index of the granted bit; 0 when gnt is zero.
- gnt_valid  output  1  high while any grant is active (OR of gnt).
- timeout  output  1  one-cycle pulse when a grant is force-released by the hold limit.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, ptr=0, hold_cnt=0.
  - Reset applied mid-grant drops the grant on the next edge; no timeout pulse is generated.
- States: IDLE, BUSY.
- IDLE:
  - If req != 0, pick the winner: the first set bit of req searching upward from ptr, wrapping 7 -> 0.
  - On the next edge: gnt = one-hot(winner), gnt_idx = winner, state=BUSY, hold_cnt=0.
  - Latency from req asserted to gnt is 1 cycle.
  - If req == 0, stay in IDLE with outputs zero.
- BUSY: the owner is the bit set in gnt. A release event is any of:
  - done=1
  - req[owner]=0 (implicit abort)
  - MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 (forced)
- BUSY, on a release event:
  - Next edge: gnt=0, state=IDLE, ptr=(owner+1) mod 8 (7 wraps to 0).
  - Simultaneous causes count as one release.
  - timeout pulses for 1 cycle only if forced and neither done nor abort was present in that cycle.
- BUSY, no release event: hold_cnt increments; gnt unchanged regardless of other req changes.
- Release always inserts exactly one IDLE cycle with gnt=0 before the next grant. This gives the resource a mandatory turnaround cycle.
- Fairness: the requester just served has lowest priority at the next arbitration. Any continuously requesting input is granted within 7 intervening grants.
- gnt_idx is derived combinationally from the registered gnt through the encoder, so it is glitch-free relative to clk.
- Invariant: gnt is zero or exactly one-hot at all times.
- hold_cnt never wraps; it is cleared on every grant.

Decomposition:
- Shared package holds:
  - state encoding constants: ST_IDLE=1'b0, ST_BUSY=1'b1
  - NUM_REQ=8
  - IDX_W=3
- Sub-module: the existing encoder_8to3, instanced for gnt -> gnt_idx.
- The rotating priority pick is implemented inline as a rotate / find-first / rotate-back in one always block.

Test Plan:
- Reset then single request: rst 2 cycles, req=8'b0000_0100.
  - gnt=8'b0000_0100, gnt_idx=2, gnt_valid=1 exactly 1 cycle later.
  - done=1 for one cycle -> gnt=0 next cycle, ptr=3.
- Round-robin rotation: req=8'hFF held, done pulsed on every BUSY cycle.
  - Grant order 0,1,2,...,7,0, with one gnt=0 cycle between each.
  - gnt_idx matches the set bit every time.
- Wrap-around: owner 7 with req=8'b1000_0001.
  - After done: IDLE cycle, then gnt=8'b0000_0001, gnt_idx=0.
  - Then with req=8'b1000_0001 still set and done: next grant is 7.
- Abort: owner 4 drops req[4] without done while req[5]=1.
  - gnt=0 next cycle, then gnt=8'b0010_0000.
  - timeout stays 0.
- Timeout: MAX_HOLD=4, req[1] held, done never asserted.
  - gnt[1] high exactly 4 cycles.
  - timeout=1 on the cycle gnt falls.
  - Re-granted to 1 after the IDLE cycle if it is the only requester.
  - Also check done on the limit cycle -> timeout=0.
- Reset mid-grant: owner 6 active, rst=1 for one edge.
  - gnt=0, gnt_idx=0, timeout=0.
  - After rst=0 with req=8'b0100_0001: winner is 0 (ptr=0).

Source files
------------

// File: rtl/rr_arbiter_8_pkg.sv
// Shared constants and types for the 8-way round-robin arbiter.
package rr_arbiter_8_pkg;

    localparam int unsigned NUM_REQ = 8;
    localparam int unsigned IDX_W   = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/encoder_8to3.sv
// One-hot to binary encoder; produces 0 for an all-zero input.
module encoder_8to3 (
    input  logic [7:0] onehot,
    output logic [2:0] idx
);

    always_comb begin
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (onehot[i]) begin
                idx = idx | 3'(i);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters with registered one-hot grant,
// release on done/abort/hold limit, and a mandatory idle turnaround cycle.
module rr_arbiter_8
    import rr_arbiter_8_pkg::*;
#(
    parameter int unsigned HOLD_W   = 8,
    parameter int unsigned MAX_HOLD = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid,
    output logic               timeout
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    localparam logic              HOLD_EN   = (MAX_HOLD != 0);

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic                 timeout_q, timeout_d;

    logic [IDX_W-1:0]     winner;
    logic                 abort;
    logic                 forced;

    encoder_8to3 u_enc (
        .onehot (gnt_q),
        .idx    (gnt_idx)
    );

    // Rotate so ptr sits at bit 0, take the first set bit, rotate the index back.
    always_comb begin
        logic [2*NUM_REQ-1:0] dbl;
        logic [NUM_REQ-1:0]   rot;
        logic [IDX_W-1:0]     first;
        dbl    = {req, req} >> ptr_q;
        rot    = dbl[NUM_REQ-1:0];
        first  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                first = IDX_W'(i);
            end
        end
        winner = first + ptr_q;
    end

    assign abort  = ~|(req & gnt_q);
    assign forced = HOLD_EN && (hold_q == HOLD_LAST);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    gnt_d   = NUM_REQ'(1) << winner;
                    hold_d  = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (done || abort || forced) begin
                    gnt_d     = '0;
                    ptr_d     = gnt_idx + 3'd1;
                    state_d   = ST_IDLE;
                    timeout_d = forced && !done && !abort;
                end else if (hold_q != '1) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = |gnt_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8 with a short hold limit of 4 cycles.
module tb_rr_arbiter_8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rr_arbiter_8 #(
        .HOLD_W   (8),
        .MAX_HOLD (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    // Advance one edge and settle past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = 8'h00;
        done = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (gnt !== 8'h00) begin
            bad++;
            $display("FAIL reset_gnt got=%h want=00", gnt);
        end
        total++;
        if (gnt_idx !== 3'd0 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL reset_outs got idx=%0d valid=%b to=%b want 0/0/0",
                     gnt_idx, gnt_valid, timeout);
        end
        step();
        total++;
        if (gnt !== 8'h00) begin
            bad++;
            $display("FAIL idle_no_req got=%h want=00", gnt);
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 8'b0000_0100;
        step();
        total++;
        if (gnt !== 8'h04 || gnt_idx !== 3'd2 || gnt_valid !== 1'b1) begin
            bad++;
            $display("FAIL single_grant got gnt=%h idx=%0d v=%b want 04/2/1",
                     gnt, gnt_idx, gnt_valid);
        end
        done = 1'b1;
        step();
        done = 1'b0;
        total++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_release got gnt=%h v=%b want 00/0", gnt, gnt_valid);
        end
        // ptr is now 3, so requester 3 beats requester 2.
        req = 8'b0000_1100;
        step();
        total++;
        if (gnt !== 8'h08 || gnt_idx !== 3'd3) begin
            bad++;
            $display("FAIL single_ptr got gnt=%h idx=%0d want 08/3", gnt, gnt_idx);
        end
        req = 8'h00;
        step();
    endtask

    task automatic test_rotation();
        logic [7:0] e;
        do_reset();
        req = 8'hFF;
        step();
        for (int i = 0; i < 9; i++) begin
            e = 8'h01 << (i % 8);
            total++;
            if (gnt !== e || gnt_idx !== 3'(i % 8)) begin
                bad++;
                $display("FAIL rotate_%0d got gnt=%h idx=%0d want %h/%0d",
                         i, gnt, gnt_idx, e, i % 8);
            end
            done = 1'b1;
            step();
            done = 1'b0;
            total++;
            if (gnt !== 8'h00) begin
                bad++;
                $display("FAIL rotate_gap_%0d got gnt=%h want=00", i, gnt);
            end
            step();
        end
        req = 8'h00;
        step();
    endtask

    task automatic test_wrap();
        do_reset();
        req = 8'h80;
        step();
        total++;
        if (gnt !== 8'h80 || gnt_idx !== 3'd7) begin
            bad++;
            $display("FAIL wrap_own7 got gnt=%h idx=%0d want 80/7", gnt, gnt_idx);
        end
        req  = 8'h81;
        done = 1'b1;
        step();
        done = 1'b0;
        total++;
        if (gnt !== 8'h00) begin
            bad++;
            $display("FAIL wrap_gap got gnt=%h want=00", gnt);
        end
        step();
        total++;
        if (gnt !== 8'h01 || gnt_idx !== 3'd0) begin
            bad++;
            $display("FAIL wrap_to0 got gnt=%h idx=%0d want 01/0", gnt, gnt_idx);
        end
        done = 1'b1;
        step();
        done = 1'b0;
        step();
        total++;
        if (gnt !== 8'h80 || gnt_idx !== 3'd7 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL wrap_back7 got gnt=%h idx=%0d to=%b want 80/7/0",
                     gnt, gnt_idx, timeout);
        end
        req = 8'h00;
        step();
    endtask

    task automatic test_abort();
        do_reset();
        req = 8'h10;
        step();
        req = 8'h20;
        step();
        total++;
        if (gnt !== 8'h00 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL abort_release got gnt=%h to=%b want 00/0", gnt, timeout);
        end
        step();
        total++;
        if (gnt !== 8'h20 || gnt_idx !== 3'd5 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL abort_next got gnt=%h idx=%0d to=%b want 20/5/0",
                     gnt, gnt_idx, timeout);
        end
        req = 8'h00;
        step();
    endtask

    task automatic test_timeout();
        do_reset();
        req = 8'h02;
        step();
        for (int k = 0; k < 4; k++) begin
            total++;
            if (gnt !== 8'h02 || timeout !== 1'b0) begin
                bad++;
                $display("FAIL hold_cycle_%0d got gnt=%h to=%b want 02/0", k, gnt, timeout);
            end
            step();
        end
        total++;
        if (gnt !== 8'h00 || timeout !== 1'b1) begin
            bad++;
            $display("FAIL timeout_fire got gnt=%h to=%b want 00/1", gnt, timeout);
        end
        step();
        total++;
        if (gnt !== 8'h02 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL timeout_regrant got gnt=%h to=%b want 02/0", gnt, timeout);
        end
        step();
        step();
        step();
        total++;
        if (gnt !== 8'h02) begin
            bad++;
            $display("FAIL limit_hold got gnt=%h want=02", gnt);
        end
        done = 1'b1;
        step();
        done = 1'b0;
        total++;
        if (gnt !== 8'h00 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL limit_with_done got gnt=%h to=%b want 00/0", gnt, timeout);
        end
        req = 8'h00;
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 8'h40;
        step();
        total++;
        if (gnt !== 8'h40) begin
            bad++;
            $display("FAIL mid_own6 got gnt=%h want=40", gnt);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if (gnt !== 8'h00 || gnt_idx !== 3'd0 || timeout !== 1'b0 || gnt_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset got gnt=%h idx=%0d to=%b v=%b want 00/0/0/0",
                     gnt, gnt_idx, timeout, gnt_valid);
        end
        req = 8'h41;
        step();
        total++;
        if (gnt !== 8'h01 || gnt_idx !== 3'd0) begin
            bad++;
            $display("FAIL mid_after got gnt=%h idx=%0d want 01/0", gnt, gnt_idx);
        end
        req = 8'h00;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst  = 1'b1;
        req  = 8'h00;
        done = 1'b0;
        test_reset();
        test_single();
        test_rotation();
        test_wrap();
        test_abort();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
